// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem and buffers
// {pc, inst} pairs in a 2-entry FIFO toward decode.
module ifetch_unit #(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_dout,
    input  logic                       redirect_valid,
    input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [31:0]                if_inst,
    output logic [IMEM_ADDR_WIDTH-1:0] if_pc
);

    localparam int AW = IMEM_ADDR_WIDTH;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_q   [2];
    logic [31:0]   inst_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          pop;
    logic          push;

    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign pop       = if_valid & if_ready;
    assign push      = fetch_en & ~redirect_valid & ((count != 2'd2) | pop);

    // Head is zeroed when empty so decode never sees stale data.
    assign if_inst = if_valid ? inst_q[rd_ptr] : 32'h0;
    assign if_pc   = if_valid ? pc_q[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= pc;
            inst_q[wr_ptr] <= imem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[AW-1:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                pc     <= pc + AW'(4);
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
